// File: rtl/t_toggle_sequencer_pkg.sv
// Shared types for the toggle sequencer: command opcodes and controller states.
package t_seq_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/t_toggle_sequencer_if.sv
// Host-side command handshake plus bank status, grouped for the sequencer port.
interface t_toggle_sequencer_if #(
    parameter int WIDTH = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             pause;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, pause,
        input  cmd_ready, q, t_vec, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, pause,
        output cmd_ready, q, t_vec, busy, done, wrap
    );
endinterface

// File: rtl/t_toggle_sequencer_tff_bank.sv
// Bank of T flip-flops; holds the only copy of the count value.
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;

    // Each bit toggles where t_vec is set; synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_q ^ t_vec;
    end

    assign q = q_q;
endmodule

// File: rtl/t_toggle_sequencer.sv
// Command-driven controller computing the toggle vector for a modulo-MOD T flip-flop bank.
//
//  state | meaning
//  IDLE  | waiting for a command, cmd_ready high
//  RUN   | applying one step per non-paused cycle, steps_q counts down
//  DONE  | one-cycle completion pulse, no toggling
module t_toggle_sequencer #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    t_toggle_sequencer_if.slave bus
);
    import t_seq_pkg::*;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             accept;
    logic             step_en;
    op_e              cmd_op;

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .t_vec (t_vec),
        .q     (q)
    );

    assign cmd_op  = op_e'(bus.cmd_op);
    assign accept  = bus.cmd_valid && (state_q == IDLE);
    assign step_en = (state_q == RUN) && !bus.pause;

    // Controller state, latched command and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_CLEAR;
            steps_q <= '0;
            val_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            steps_q <= steps_d;
            val_q   <= val_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state: CLEAR/LOAD run as a single step, counts as cmd_arg steps.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        steps_d = steps_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = cmd_op;
                    val_d = (bus.cmd_arg > MAX_VAL) ? MAX_VAL : bus.cmd_arg;
                    if (cmd_op == OP_UP || cmd_op == OP_DOWN) begin
                        steps_d = bus.cmd_arg;
                        state_d = (bus.cmd_arg == '0) ? DONE : RUN;
                    end else begin
                        steps_d = WIDTH'(1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!bus.pause) begin
                    steps_d = steps_q - WIDTH'(1);
                    if (steps_q == WIDTH'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Toggle vector and wrap detection for the current step.
    always_comb begin
        t_vec  = '0;
        wrap_d = 1'b0;
        carry  = 1'b1;
        if (step_en) begin
            case (op_q)
                OP_CLEAR: t_vec = q;
                OP_LOAD:  t_vec = q ^ val_q;
                OP_UP: begin
                    if (q == MAX_VAL) begin
                        t_vec  = q;
                        wrap_d = 1'b1;
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            t_vec[i] = carry;
                            carry    = carry & q[i];
                        end
                    end
                end
                OP_DOWN: begin
                    if (q == '0) begin
                        t_vec  = MAX_VAL;
                        wrap_d = 1'b1;
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            t_vec[i] = carry;
                            carry    = carry & ~q[i];
                        end
                    end
                end
                default: t_vec = '0;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.wrap      = wrap_q;
    assign bus.t_vec     = t_vec;
    assign bus.q         = q;
endmodule

// File: tb/tb_t_toggle_sequencer.sv
// Bench for t_toggle_sequencer: directed scenarios plus random commands against a count model.
module tb_t_toggle_sequencer;
    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    t_toggle_sequencer_if #(.WIDTH(WIDTH)) bus ();

    t_toggle_sequencer #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors  = 0;
    int checks  = 0;
    int model_q = 0;

    function automatic int step_next(input int op, input int cur, input int arg);
        case (op)
            0:       return 0;
            1:       return (arg > MOD - 1) ? MOD - 1 : arg;
            2:       return (cur + 1) % MOD;
            default: return (cur + MOD - 1) % MOD;
        endcase
    endfunction

    function automatic bit step_wraps(input int op, input int cur);
        return (op == 2 && cur == MOD - 1) || (op == 3 && cur == 0);
    endfunction

    // Issue one command and follow it cycle by cycle until back in IDLE.
    task automatic test_command(input int op, input int arg, input logic [31:0] pmask,
                                input string tag);
        int  steps;
        int  cyc;
        int  nxt;
        int  guard;
        bit  exp_wrap;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait cmd_ready=%b required 1", tag, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        bus.cmd_arg   = WIDTH'(arg);
        bus.pause     = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        steps = (op >= 2) ? arg : 1;
        cyc   = 0;
        while (steps > 0 && cyc < 100) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s run_status cyc=%0d busy=%b done=%b ready=%b required 1/0/0",
                         tag, cyc, bus.busy, bus.done, bus.cmd_ready);
            end
            bus.pause = (cyc < 32) ? pmask[cyc] : 1'b0;
            #1;
            nxt = bus.pause ? model_q : step_next(op, model_q, arg);
            checks++;
            if (bus.t_vec !== WIDTH'(model_q ^ nxt)) begin
                errors++;
                $display("FAIL %s t_vec cyc=%0d got=%0d required=%0d",
                         tag, cyc, bus.t_vec, model_q ^ nxt);
            end
            exp_wrap = !bus.pause && step_wraps(op, model_q);
            if (!bus.pause) steps--;
            @(posedge clk); #1;
            model_q = nxt;
            cyc++;
            checks++;
            if (bus.q !== WIDTH'(model_q) || bus.wrap !== exp_wrap) begin
                errors++;
                $display("FAIL %s step cyc=%0d q=%0d wrap=%b required q=%0d wrap=%b",
                         tag, cyc, bus.q, bus.wrap, model_q, exp_wrap);
            end
        end
        bus.pause = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.t_vec !== '0) begin
            errors++;
            $display("FAIL %s done_pulse done=%b busy=%b ready=%b t_vec=%0d required 1/1/0/0",
                     tag, bus.done, bus.busy, bus.cmd_ready, bus.t_vec);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            bus.wrap !== 1'b0 || bus.q !== WIDTH'(model_q)) begin
            errors++;
            $display("FAIL %s back_idle done=%b busy=%b ready=%b wrap=%b q=%0d required 0/0/1/0 q=%0d",
                     tag, bus.done, bus.busy, bus.cmd_ready, bus.wrap, bus.q, model_q);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.q !== '0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.wrap !== 1'b0 || bus.t_vec !== '0) begin
            errors++;
            $display("FAIL reset q=%0d ready=%b busy=%b done=%b wrap=%b t_vec=%0d required 0/1/0/0/0/0",
                     bus.q, bus.cmd_ready, bus.busy, bus.done, bus.wrap, bus.t_vec);
        end
        model_q = 0;
    endtask

    task automatic test_reset_mid_run();
        test_command(1, 2, 32'h0, "mid_load2");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_arg   = WIDTH'(7);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.q !== WIDTH'(4) || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_progress q=%0d busy=%b required q=4 busy=1", bus.q, bus.busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.q !== '0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset q=%0d ready=%b busy=%b done=%b required 0/1/0/0",
                     bus.q, bus.cmd_ready, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        model_q = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0 || bus.q !== '0 || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_run_after cyc=%0d done=%b q=%0d ready=%b required 0/0/1",
                         i, bus.done, bus.q, bus.cmd_ready);
            end
        end
    endtask

    task automatic test_up_wrap();
        test_command(1, 6, 32'h0, "up_load6");
        test_command(2, 5, 32'h0, "up5");
        checks++;
        if (bus.q !== WIDTH'(1)) begin
            errors++;
            $display("FAIL up_wrap_final q=%0d required 1", bus.q);
        end
    endtask

    task automatic test_down_wrap();
        test_command(1, 1, 32'h0, "down_load1");
        test_command(3, 3, 32'h0, "down3");
        checks++;
        if (bus.q !== WIDTH'(8)) begin
            errors++;
            $display("FAIL down_wrap_final q=%0d required 8", bus.q);
        end
    endtask

    task automatic test_saturate();
        test_command(1, 15, 32'h0, "load15");
        checks++;
        if (bus.q !== WIDTH'(9)) begin
            errors++;
            $display("FAIL load_saturate q=%0d required 9", bus.q);
        end
        test_command(2, 0, 32'h0, "up0");
        checks++;
        if (bus.q !== WIDTH'(9)) begin
            errors++;
            $display("FAIL up0_hold q=%0d required 9", bus.q);
        end
    endtask

    task automatic test_pause();
        test_command(0, 0, 32'h0, "pause_clear");
        test_command(2, 4, 32'h0000_0006, "up4_paused");
        checks++;
        if (bus.q !== WIDTH'(4)) begin
            errors++;
            $display("FAIL pause_final q=%0d required 4", bus.q);
        end
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        int q_start;
        q_start = model_q;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_arg   = WIDTH'(3);
        @(posedge clk); #1;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = '0;
        low_cycles = 0;
        while (bus.cmd_ready !== 1'b1 && low_cycles < 20) begin
            @(posedge clk); #1;
            low_cycles++;
        end
        checks++;
        if (low_cycles !== 4 || bus.q !== WIDTH'((q_start + 3) % MOD)) begin
            errors++;
            $display("FAIL b2b_hold cycles_busy=%0d q=%0d required 4 q=%0d",
                     low_cycles, bus.q, (q_start + 3) % MOD);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.q !== WIDTH'((q_start + 3) % MOD)) begin
            errors++;
            $display("FAIL b2b_accept busy=%b q=%0d required 1 q=%0d",
                     bus.busy, bus.q, (q_start + 3) % MOD);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.q !== '0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_clear q=%0d done=%b required 0/1", bus.q, bus.done);
        end
        @(posedge clk); #1;
        model_q = 0;
    endtask

    task automatic test_random();
        int op;
        int arg;
        logic [31:0] pm;
        for (int n = 0; n < 16; n++) begin
            op  = int'($urandom_range(0, 3));
            arg = int'($urandom_range(0, 15));
            pm  = $urandom & $urandom;
            test_command(op, arg, pm, $sformatf("rand%0d_op%0d_arg%0d", n, op, arg));
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = '0;
        bus.pause     = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        test_reset();
        test_reset_mid_run();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_pause();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
